core_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for RV64M MUL/DIV/REM (incl. W forms) issued in the EX stage.

---
 rtl/core_muldiv_seq_pkg.sv | 24 ++
 rtl/core_muldiv_seq_if.sv | 27 ++
 rtl/core_muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_core_muldiv_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/core_muldiv_seq_pkg.sv
// Shared types for the RV64M multi-cycle multiply/divide sequencer.
// Opcode constants, funct3 op codes and sequencer states.
package core_muldiv_seq_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/core_muldiv_seq_if.sv
// EX-stage <-> muldiv sequencer bundle.
// master = core_ex (issues op, takes stall/done/result); slave = sequencer.
interface core_muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            i_start;
  logic [2:0]      i_funct3;
  logic            i_op32;
  logic [XLEN-1:0] i_dat_a;
  logic [XLEN-1:0] i_dat_b;
  logic            i_flush;
  logic            o_stall;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_funct3, i_op32,
    output i_dat_a, i_dat_b, i_flush,
    input  o_stall, o_done, o_result
  );

  modport slave (
    input  i_start, i_funct3, i_op32,
    input  i_dat_a, i_dat_b, i_flush,
    output o_stall, o_done, o_result
  );
endinterface

// File: rtl/core_muldiv_seq.sv
// Iterative RV64M MUL/DIV/REM sequencer (shift-add / restoring).
// Ports: i_clk, i_reset (sync, active-high), md (slave bundle).
module core_muldiv_seq
  import core_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic               i_clk,
  input logic               i_reset,
  core_muldiv_seq_if.slave  md
);

  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);

  typedef logic [XLEN-1:0] word_t;

  function automatic word_t ext32(word_t x, logic sgn);
    return {{(XLEN-32){sgn & x[31]}}, x[31:0]};
  endfunction

  function automatic word_t cneg(word_t x, logic n);
    return n ? -x : x;
  endfunction

  function automatic word_t wfix(word_t x, logic w);
    return w ? ext32(x, 1'b1) : x;
  endfunction

  muldiv_state_t state, state_nx;
  muldiv_op_t    op, op_q;

  logic          w_q, neg_x, neg_r;
  logic [CW-1:0] cnt;
  logic [W2-1:0] acc, b_m;
  word_t         a_q, res_q;

  logic  sgn_a, sgn_b, is_div, neg_a, neg_b;
  logic  div_zero, div_ovf, special, go;
  word_t ext_a, ext_b, mag_a, mag_b;
  word_t min_v, sp_res;

  always_comb begin
    op    = muldiv_op_t'(md.i_funct3);
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (1'b1)
      op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      op == MD_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
    is_div = md.i_funct3[2];
    ext_a  = md.i_op32 ? ext32(md.i_dat_a, sgn_a) : md.i_dat_a;
    ext_b  = md.i_op32 ? ext32(md.i_dat_b, sgn_b) : md.i_dat_b;
    neg_a  = sgn_a & ext_a[XLEN-1];
    neg_b  = sgn_b & ext_b[XLEN-1];
    mag_a  = cneg(ext_a, neg_a);
    mag_b  = cneg(ext_b, neg_b);
    // W forms compare against the sign-extended 32-bit minimum
    min_v  = md.i_op32 ? {{(XLEN-31){1'b1}}, 31'b0}
                       : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && (ext_b == '0);
    div_ovf  = is_div && sgn_a && (ext_a == min_v)
               && (ext_b == '1);
    special  = div_zero || div_ovf;
    // rem bit is funct3[1] within the divide group
    if (md.i_funct3[1])
      sp_res = div_zero ? ext_a : '0;
    else
      sp_res = div_zero ? '1 : ext_a;
    sp_res = wfix(sp_res, md.i_op32);
  end

  always_comb begin
    state_nx  = state;
    md.o_stall = 1'b0;
    md.o_done  = 1'b0;
    go         = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (md.i_start && !md.i_flush) begin
          go         = 1'b1;
          md.o_stall = 1'b1;
          state_nx   = special ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        md.o_stall = !md.i_flush;
        if (cnt == CW'(1))
          state_nx = MD_DONE;
      end
      MD_DONE: begin
        md.o_done = 1'b1;
        state_nx  = MD_IDLE;
      end
      default: state_nx = MD_IDLE;
    endcase
    if (md.i_flush)
      state_nx = MD_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= MD_IDLE;
    else
      state <= state_nx;
  end

  logic          op_div;
  logic [XLEN:0] sh, diff;
  logic [W2-1:0] acc_nx, bm_nx, prod;
  word_t         aq_nx, fin;

  always_comb begin
    op_div = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    sh     = {acc[XLEN-1:0], a_q[XLEN-1]};
    diff   = sh - {1'b0, b_m[XLEN-1:0]};
    if (op_div) begin
      acc_nx = {{XLEN{1'b0}},
                diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]};
      aq_nx  = {a_q[XLEN-2:0], ~diff[XLEN]};
      bm_nx  = b_m;
    end else begin
      acc_nx = acc + (a_q[0] ? b_m : '0);
      aq_nx  = a_q >> 1;
      bm_nx  = b_m << 1;
    end
    // final value uses the last step's outputs so it lands with DONE
    prod = neg_x ? -acc_nx : acc_nx;
    unique case (1'b1)
      op_q == MD_MUL: fin = prod[XLEN-1:0];
      op_q inside {MD_MULH, MD_MULHSU, MD_MULHU}:
        fin = prod[W2-1:XLEN];
      op_q inside {MD_DIV, MD_DIVU}:
        fin = cneg(aq_nx, neg_x);
      default:
        fin = cneg(acc_nx[XLEN-1:0], neg_r);
    endcase
    fin = wfix(fin, w_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q  <= MD_MUL;
      w_q   <= 1'b0;
      neg_x <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_m   <= '0;
      res_q <= '0;
    end else if (go) begin
      op_q  <= op;
      w_q   <= md.i_op32;
      neg_x <= neg_a ^ neg_b;
      neg_r <= neg_a;
      cnt   <= md.i_op32 ? CW'(32) : CW'(XLEN);
      acc   <= '0;
      b_m   <= {{XLEN{1'b0}}, mag_b};
      // W divide: park the 32-bit dividend at the top so
      // 32 shifts leave the quotient in the low half
      a_q   <= (is_div && md.i_op32) ? (mag_a << 32) : mag_a;
      if (special)
        res_q <= sp_res;
    end else if (state == MD_CALC && !md.i_flush) begin
      acc <= acc_nx;
      a_q <= aq_nx;
      b_m <= bm_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1))
        res_q <= fin;
    end
  end

  assign md.o_result = res_q;

endmodule

// File: tb/tb_core_muldiv_seq.sv
// Directed bench for core_muldiv_seq.
// Vector table plus flush / reset / start-with-flush sequences.
module tb_core_muldiv_seq;
  import core_muldiv_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  core_muldiv_seq_if #(.XLEN(64)) md ();

  core_muldiv_seq #(.XLEN(64)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .md      (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    int scnt;
    md.i_funct3 = v.f3;
    md.i_op32   = v.w;
    md.i_dat_a  = v.a;
    md.i_dat_b  = v.b;
    md.i_start  = 1'b1;
    #1;
    lat  = 0;
    scnt = 0;
    if (md.o_stall) scnt++;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (md.o_done) begin
        lat = c;
        break;
      end
      if (md.o_stall) scnt++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(v.lat));
    chk({nm, " result"}, md.o_result, v.exp);
    chk({nm, " stall_cycles"}, 64'(scnt), 64'(v.lat));
    chk({nm, " stall_at_done"}, 64'(md.o_stall), 64'd0);
    md.i_start = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " done_pulse"}, 64'(md.o_done), 64'd0);
    chk({nm, " hold"}, md.o_result, v.exp);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;

  vec_t v;
  int   dcnt;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vt[0]  = '{MD_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, 65};
    vt[1]  = '{MD_MULHU, 1'b0, ONES, ONES,
               64'hFFFF_FFFF_FFFF_FFFE, 65};
    vt[2]  = '{MD_DIV, 1'b1, 64'h0000_0000_8000_0000, ONES,
               64'hFFFF_FFFF_8000_0000, 1};
    vt[3]  = '{MD_DIVU, 1'b0, 64'd100, 64'd0, ONES, 1};
    vt[4]  = '{MD_REMU, 1'b0, 64'd100, 64'd0, 64'd100, 1};
    vt[5]  = '{MD_REM, 1'b0, M7, 64'd2, ONES, 65};
    vt[6]  = '{MD_DIV, 1'b0, M7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 65};
    vt[7]  = '{MD_DIV, 1'b1, M7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 33};
    vt[8]  = '{MD_MULH, 1'b0, MIN, 64'd2, ONES, 65};
    vt[9]  = '{MD_MULHSU, 1'b0, ONES, 64'd2, ONES, 65};
    vt[10] = '{MD_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 33};
    vt[11] = '{MD_DIV, 1'b0, MIN, ONES, MIN, 1};
    vt[12] = '{MD_REM, 1'b0, MIN, ONES, 64'd0, 1};
    vt[13] = '{MD_REMU, 1'b1, 64'h0000_0001_8000_0005, 64'd0,
               64'hFFFF_FFFF_8000_0005, 1};
    vt[14] = '{MD_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd2,
               64'h7FFF_FFFF, 33};
    vt[15] = '{MD_DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 65};
    vt[16] = '{MD_REMU, 1'b0, 64'd1000, 64'd7, 64'd6, 65};
    vt[17] = '{MD_REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
               ONES, 33};
    vt[18] = '{MD_MULHU, 1'b0, 64'h1_0000_0000,
               64'h1_0000_0000, 64'd1, 65};

    rst         = 1'b1;
    md.i_start  = 1'b0;
    md.i_flush  = 1'b0;
    md.i_funct3 = 3'd0;
    md.i_op32   = 1'b0;
    md.i_dat_a  = '0;
    md.i_dat_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall", 64'(md.o_stall), 64'd0);
    chk("reset done", 64'(md.o_done), 64'd0);
    chk("reset result", md.o_result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++)
      run_vec($sformatf("vec%0d", i), vt[i]);

    // flush at cycle 10 of a divide
    md.i_funct3 = MD_DIVU;
    md.i_op32   = 1'b0;
    md.i_dat_a  = 64'd100;
    md.i_dat_b  = 64'd7;
    md.i_start  = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("flush pre stall", 64'(md.o_stall), 64'd1);
    md.i_flush = 1'b1;
    md.i_start = 1'b0;
    @(posedge clk);
    #1;
    md.i_flush = 1'b0;
    chk("flush stall", 64'(md.o_stall), 64'd0);
    chk("flush done", 64'(md.o_done), 64'd0);
    dcnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (md.o_done || md.o_stall) dcnt++;
    end
    chk("flush quiet", 64'(dcnt), 64'd0);
    v = '{MD_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 65};
    run_vec("post_flush_mul", v);

    // flush wins over start in IDLE
    md.i_funct3 = MD_MUL;
    md.i_dat_a  = 64'd5;
    md.i_dat_b  = 64'd5;
    md.i_start  = 1'b1;
    md.i_flush  = 1'b1;
    #1;
    chk("flush_vs_start stall", 64'(md.o_stall), 64'd0);
    @(posedge clk);
    #1;
    md.i_start = 1'b0;
    md.i_flush = 1'b0;
    dcnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (md.o_done || md.o_stall) dcnt++;
    end
    chk("flush_vs_start quiet", 64'(dcnt), 64'd0);

    // reset mid-op clears result and never pulses done
    md.i_start = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst        = 1'b1;
    md.i_start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst stall", 64'(md.o_stall), 64'd0);
    chk("midrst done", 64'(md.o_done), 64'd0);
    chk("midrst result", md.o_result, 64'd0);
    rst  = 1'b0;
    dcnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (md.o_done) dcnt++;
    end
    chk("midrst quiet", 64'(dcnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
